// File: rtl/d16_scoreboard_pkg.sv
// Shared d16 opcode values and opcode classification for the register scoreboard.
// Each opcode class is defined once here, so every block that decodes opcodes agrees on it.
package d16_scoreboard_pkg;

  localparam logic [7:0] D16_OP_NOP = 8'h00;
  localparam logic [7:0] D16_OP_ADD = 8'h01;
  localparam logic [7:0] D16_OP_SUB = 8'h02;
  localparam logic [7:0] D16_OP_SHL = 8'h03;
  localparam logic [7:0] D16_OP_SHR = 8'h04;
  localparam logic [7:0] D16_OP_EQU = 8'h05;
  localparam logic [7:0] D16_OP_COP = 8'h06;
  localparam logic [7:0] D16_OP_AFC = 8'h07;
  localparam logic [7:0] D16_OP_LOD = 8'h08;
  localparam logic [7:0] D16_OP_LOP = 8'h09;
  localparam logic [7:0] D16_OP_STP = 8'h0A;
  localparam logic [7:0] D16_OP_JMZ = 8'h0B;
  localparam logic [7:0] D16_OP_STR = 8'h0C;
  localparam logic [7:0] D16_OP_JMP = 8'h0D;

  typedef struct packed {
    logic wr;     // writes register a
    logic rd_b;   // reads register b
    logic rd_bc;  // also reads register c
  } op_class_t;

  function automatic logic d16_writes_reg(input logic [7:0] op);
    case (op)
      D16_OP_ADD, D16_OP_SUB, D16_OP_SHL, D16_OP_SHR, D16_OP_EQU,
      D16_OP_COP, D16_OP_AFC, D16_OP_LOD, D16_OP_LOP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic d16_reads_bc(input logic [7:0] op);
    case (op)
      D16_OP_ADD, D16_OP_SUB, D16_OP_SHL, D16_OP_SHR, D16_OP_EQU,
      D16_OP_STP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic d16_reads_b(input logic [7:0] op);
    case (op)
      D16_OP_JMZ, D16_OP_COP, D16_OP_STR: return 1'b1;
      default: return d16_reads_bc(op);
    endcase
  endfunction

  function automatic op_class_t d16_classify(input logic [7:0] op);
    op_class_t c;
    c.wr    = d16_writes_reg(op);
    c.rd_b  = d16_reads_b(op);
    c.rd_bc = d16_reads_bc(op);
    return c;
  endfunction

endpackage

// File: rtl/d16_sb_counter.sv
// Saturating pending-write counter for one architectural register.
// The caller keeps inc from firing at the maximum; a decrement at zero is reported and ignored.
module d16_sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nz_o,
  output logic             err_dec_zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i)
      cnt_d = cnt_q + CNT_W'(1);
    else if (dec_i && !inc_i && cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o          = cnt_q;
  assign nz_o           = (cnt_q != '0);
  assign err_dec_zero_o = dec_i && (cnt_q == '0);

endmodule

// File: rtl/d16_scoreboard.sv
// Register scoreboard: counts in-flight writes per register from issue to writeback
// and stalls LI/DI while any source register still has a write outstanding.
module d16_scoreboard
  import d16_scoreboard_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int NREGS = 2**REG_W,
  parameter int CNT_W = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [7:0]       li_di_op,
  input  logic [REG_W-1:0] li_di_a,
  input  logic [REG_W-1:0] li_di_b,
  input  logic [REG_W-1:0] li_di_c,
  input  logic             jmp,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_a,
  output logic [7:0]       li_di_op_out,
  output logic             en,
  output logic [NREGS-1:0] busy,
  output logic             sb_err
);

  op_class_t                   cls;
  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [NREGS-1:0]            nz, inc, dec, err_vec;
  logic                        hazard, full, stall, issue;
  logic                        sb_err_q;

  assign cls = d16_classify(li_di_op);

  // Counter values before the edge are used: a retiring write only unblocks readers next cycle.
  assign hazard = cls.rd_b && (nz[li_di_b] || (cls.rd_bc && nz[li_di_c]));
  // A same-cycle retire on the destination frees a slot, so a full counter can still accept.
  assign full   = cls.wr && (cnt[li_di_a] == {CNT_W{1'b1}}) && !(wb_valid && wb_a == li_di_a);
  assign stall  = ~jmp & (hazard | full);
  assign issue  = cls.wr & ~stall & ~jmp;

  assign en           = ~stall;
  assign li_di_op_out = stall ? 8'h00 : li_di_op;

  for (genvar r = 0; r < NREGS; r++) begin : g_cnt
    assign inc[r] = issue    && (li_di_a == REG_W'(r));
    assign dec[r] = wb_valid && (wb_a    == REG_W'(r));

    d16_sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i          (sys_clk),
      .rst_ni         (sys_rst),
      .inc_i          (inc[r]),
      .dec_i          (dec[r]),
      .cnt_o          (cnt[r]),
      .nz_o           (nz[r]),
      .err_dec_zero_o (err_vec[r])
    );
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst)       sb_err_q <= 1'b0;
    else if (|err_vec)  sb_err_q <= 1'b1;
  end

  assign busy   = nz;
  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_d16_scoreboard.sv
// Self-checking bench for d16_scoreboard: directed scenarios plus randomized traffic
// compared against a per-register pending-count model.
module tb_d16_scoreboard;
  import d16_scoreboard_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [7:0]  op = '0;
  logic [3:0]  a = '0, b = '0, c = '0, wba = '0;
  logic        jmp = 1'b0, wbv = 1'b0;
  logic [7:0]  op_out;
  logic        en, sb_err;
  logic [15:0] busy;

  int total = 0;
  int bad   = 0;
  int m_cnt [16];
  bit m_err;

  d16_scoreboard dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .li_di_op(op), .li_di_a(a), .li_di_b(b),
    .li_di_c(c), .jmp(jmp), .wb_valid(wbv), .wb_a(wba), .li_di_op_out(op_out),
    .en(en), .busy(busy), .sb_err(sb_err)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic bit m_wr(input logic [7:0] o);
    return o inside {D16_OP_ADD, D16_OP_SUB, D16_OP_SHL, D16_OP_SHR, D16_OP_EQU,
                     D16_OP_COP, D16_OP_AFC, D16_OP_LOD, D16_OP_LOP};
  endfunction

  function automatic bit m_stall();
    bit two, one, hz, fl;
    two = op inside {D16_OP_ADD, D16_OP_SUB, D16_OP_SHL, D16_OP_SHR, D16_OP_EQU, D16_OP_STP};
    one = op inside {D16_OP_JMZ, D16_OP_COP, D16_OP_STR};
    hz  = (two && (m_cnt[b] > 0 || m_cnt[c] > 0)) || (one && m_cnt[b] > 0);
    fl  = m_wr(op) && m_cnt[a] == 3 && !(wbv && wba == a);
    return !jmp && (hz || fl);
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] v;
    for (int r = 0; r < 16; r++) v[r] = (m_cnt[r] != 0);
    return v;
  endfunction

  function automatic logic [7:0] m_op_out();
    return m_stall() ? 8'h00 : op;
  endfunction

  task automatic drive(input logic [7:0] o, input int aa, input int bb, input int cc,
                       input bit j, input bit wv, input int wa);
    op = o; a = 4'(aa); b = 4'(bb); c = 4'(cc); jmp = j; wbv = wv; wba = 4'(wa);
    #1;
  endtask

  task automatic idle();
    drive(D16_OP_NOP, 0, 0, 0, 0, 0, 0);
  endtask

  // Advances one clock, applying the model's pending-count rules to the inputs held this cycle.
  task automatic tick();
    int  nxt [16];
    bit  iss, nerr;
    nxt  = m_cnt;
    nerr = m_err;
    iss  = m_wr(op) && !m_stall() && !jmp;
    if (iss && wbv && a == wba) begin
      if (m_cnt[wba] == 0) nerr = 1;
    end else begin
      if (iss) nxt[a] = nxt[a] + 1;
      if (wbv) begin
        if (m_cnt[wba] == 0) nerr = 1;
        else nxt[wba] = nxt[wba] - 1;
      end
    end
    @(posedge sys_clk);
    m_cnt = nxt;
    m_err = nerr;
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    idle();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_err = 0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    do_reset();
    drive(D16_OP_ADD, 1, 2, 3, 0, 0, 0);
    total++; if (busy !== 16'h0) begin bad++; $display("FAIL reset_busy: got %h want 0000", busy); end
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", sb_err); end
    total++; if (en !== 1'b1) begin bad++; $display("FAIL reset_en: got %b want 1", en); end
    total++; if (op_out !== D16_OP_ADD) begin bad++; $display("FAIL reset_op: got %h want %h", op_out, D16_OP_ADD); end
  endtask

  task automatic test_raw();
    do_reset();
    drive(D16_OP_ADD, 1, 2, 3, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(D16_OP_ADD, 4, 1, 5, 0, 0, 0);
      total++; if (en !== 1'b0) begin bad++; $display("FAIL raw_en_stall: got %b want 0", en); end
      total++; if (op_out !== 8'h00) begin bad++; $display("FAIL raw_op_stall: got %h want 00", op_out); end
      tick();
    end
    drive(D16_OP_ADD, 4, 1, 5, 0, 1, 1);
    total++; if (en !== 1'b0) begin bad++; $display("FAIL raw_no_bypass: got %b want 0", en); end
    tick();
    drive(D16_OP_ADD, 4, 1, 5, 0, 0, 0);
    total++; if (en !== 1'b1) begin bad++; $display("FAIL raw_release_en: got %b want 1", en); end
    total++; if (op_out !== D16_OP_ADD) begin bad++; $display("FAIL raw_release_op: got %h want %h", op_out, D16_OP_ADD); end
    tick(); idle();
    total++; if (busy !== 16'h0010) begin bad++; $display("FAIL raw_busy: got %h want 0010", busy); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(D16_OP_AFC, 2, 0, 0, 0, 0, 0); tick();
    drive(D16_OP_AFC, 2, 0, 0, 0, 1, 2);
    total++; if (en !== 1'b1) begin bad++; $display("FAIL same_en: got %b want 1", en); end
    tick(); idle();
    total++; if (busy[2] !== 1'b1) begin bad++; $display("FAIL same_busy: got %b want 1", busy[2]); end
    drive(D16_OP_NOP, 0, 0, 0, 0, 1, 2); tick(); idle();
    total++; if (busy[2] !== 1'b0) begin bad++; $display("FAIL same_count_one: got %b want 0", busy[2]); end
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL same_err: got %b want 0", sb_err); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(D16_OP_AFC, 7, 0, 0, 0, 0, 0);
      total++; if (en !== 1'b1) begin bad++; $display("FAIL full_fill_en%0d: got %b want 1", i, en); end
      tick();
    end
    drive(D16_OP_AFC, 7, 0, 0, 0, 0, 0);
    total++; if (en !== 1'b0) begin bad++; $display("FAIL full_stall_en: got %b want 0", en); end
    total++; if (op_out !== 8'h00) begin bad++; $display("FAIL full_stall_op: got %h want 00", op_out); end
    tick();
    drive(D16_OP_AFC, 7, 0, 0, 0, 1, 7);
    total++; if (en !== 1'b1) begin bad++; $display("FAIL full_wb_en: got %b want 1", en); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(D16_OP_NOP, 0, 0, 0, 0, 1, 7);
      total++; if (busy[7] !== 1'b1) begin bad++; $display("FAIL full_drain%0d: got %b want 1", i, busy[7]); end
      tick();
    end
    idle();
    total++; if (busy[7] !== 1'b0) begin bad++; $display("FAIL full_empty: got %b want 0", busy[7]); end
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL full_err: got %b want 0", sb_err); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(D16_OP_AFC, 1, 0, 0, 0, 0, 0); tick();
    drive(D16_OP_JMZ, 0, 1, 0, 1, 0, 0);
    total++; if (en !== 1'b1) begin bad++; $display("FAIL flush_en: got %b want 1", en); end
    total++; if (op_out !== D16_OP_JMZ) begin bad++; $display("FAIL flush_op: got %h want %h", op_out, D16_OP_JMZ); end
    tick();
    drive(D16_OP_AFC, 5, 0, 0, 1, 0, 0); tick();
    drive(D16_OP_JMZ, 0, 1, 0, 0, 0, 0);
    total++; if (en !== 1'b0) begin bad++; $display("FAIL flush_still_busy: got %b want 0", en); end
    total++; if (busy !== 16'h0002) begin bad++; $display("FAIL flush_busy: got %h want 0002", busy); end
    drive(D16_OP_NOP, 0, 0, 0, 0, 1, 1); tick();
    drive(D16_OP_JMZ, 0, 1, 0, 0, 0, 0);
    total++; if (en !== 1'b1) begin bad++; $display("FAIL flush_retired: got %b want 1", en); end
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL flush_err: got %b want 0", sb_err); end
  endtask

  task automatic test_error();
    do_reset();
    drive(D16_OP_NOP, 0, 0, 0, 0, 1, 9);
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL err_pre: got %b want 0", sb_err); end
    tick(); idle();
    total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", sb_err); end
    total++; if (busy[9] !== 1'b0) begin bad++; $display("FAIL err_nowrap: got %b want 0", busy[9]); end
    drive(D16_OP_AFC, 9, 0, 0, 0, 0, 0); tick();
    drive(D16_OP_NOP, 0, 0, 0, 0, 1, 9); tick(); idle();
    total++; if (busy[9] !== 1'b0) begin bad++; $display("FAIL err_count: got %b want 0", busy[9]); end
    tick(); tick();
    total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", sb_err); end
  endtask

  task automatic test_async_reset();
    drive(D16_OP_ADD, 3, 0, 0, 0, 0, 0); tick();
    drive(D16_OP_ADD, 3, 0, 0, 0, 0, 0); tick();
    drive(D16_OP_ADD, 6, 3, 0, 0, 0, 0);
    total++; if (en !== 1'b0) begin bad++; $display("FAIL areset_pre_en: got %b want 0", en); end
    #2 sys_rst = 1'b0;
    #1;
    total++; if (busy !== 16'h0) begin bad++; $display("FAIL areset_busy: got %h want 0000", busy); end
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL areset_err: got %b want 0", sb_err); end
    total++; if (en !== 1'b1) begin bad++; $display("FAIL areset_en: got %b want 1", en); end
    @(negedge sys_clk);
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_err = 0;
    idle();
    sys_rst = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_random();
    int wr;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      wr = $urandom_range(0, 5);
      for (int k = 0; k < 6; k++) if (m_cnt[(wr + k) % 6] != 0) begin wr = (wr + k) % 6; break; end
      if ($urandom_range(0, 15) == 0) wr = $urandom_range(6, 15);
      drive(8'($urandom_range(0, 13)), $urandom_range(0, 5), $urandom_range(0, 5),
            $urandom_range(0, 5), $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, wr);
      total++; if (en !== !m_stall()) begin bad++; $display("FAIL rnd_en@%0d: got %b want %b", i, en, !m_stall()); end
      total++; if (op_out !== m_op_out()) begin bad++; $display("FAIL rnd_op@%0d: got %h want %h", i, op_out, m_op_out()); end
      total++; if (busy !== m_busy()) begin bad++; $display("FAIL rnd_busy@%0d: got %h want %h", i, busy, m_busy()); end
      total++; if (sb_err !== m_err) begin bad++; $display("FAIL rnd_err@%0d: got %b want %b", i, sb_err, m_err); end
      tick();
    end
  endtask

  initial begin
    @(negedge sys_clk);
    test_reset();
    test_raw();
    test_same_cycle();
    test_full();
    test_flush();
    test_error();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
